inst_mem_arbiter: RTL

- Shares the single combinational instruction ROM between two requesters:
  - CPU fetch stage (port F).
  - Debug/monitor read port (port D).
- Drives the ROM ce/addr, captures ROM data into per-port response registers with 1-cycle latency.
- Fetch has priority, with a bounded-starvation guarantee for debug.
- Sits between the PC/IF stage and the instruction memory.

---
 rtl/inst_mem_arbiter_pkg.sv | 15 +
 rtl/inst_arb_prio.sv | 47 ++++
 rtl/inst_mem_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/inst_mem_arbiter_pkg.sv
// Shared constants for the instruction-ROM arbiter: ROM enable encodings,
// the all-zero word, and default arbitration parameters.
// Imported by inst_arb_prio and inst_mem_arbiter.
package inst_mem_arbiter_pkg;

  localparam logic        RomEnable  = 1'b1;
  localparam logic        RomDisable = 1'b0;
  localparam logic [31:0] Zero       = 32'h0000_0000;

  // Default number of consecutive cycles debug may lose to fetch.
  localparam int unsigned STARVE_MAX_DEFAULT = 4;
  // Default starvation counter width; must be able to hold STARVE_MAX.
  localparam int unsigned CNT_W_DEFAULT      = 4;

endpackage

// File: rtl/inst_arb_prio.sv
// Fetch-priority winner select with bounded debug starvation.
// Latency: grant is combinational; starvation counter updates on the clock edge.
// Backpressure: none; at most one one-hot grant per cycle, forced low in reset.
module inst_arb_prio
  import inst_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_f_eff,
  input  logic i_d_req,
  output logic o_gnt_f,
  output logic o_gnt_d
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_d_turn;
  logic             w_win_f;
  logic             w_win_d;

  // Debug takes the slot once it has lost STARVE_MAX consecutive contested cycles.
  always_comb begin
    w_d_turn = (r_starve_cnt == CntMax);
    w_win_f  = i_f_eff & ~(i_d_req & w_d_turn);
    w_win_d  = i_d_req & ~w_win_f;
  end

  assign o_gnt_f = i_rst_n & w_win_f;
  assign o_gnt_d = i_rst_n & w_win_d;

  // Count contested cycles lost by debug; clear whenever debug wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_win_d) begin
      r_starve_cnt <= '0;
    end else if (w_win_f && i_d_req && (r_starve_cnt != CntSat)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one combinational instruction ROM between fetch (F) and debug (D);
// optional misalignment trap under ARB_ALIGN_CHECK_EN.
// Latency: grant at T -> rvalid/rdata at T+1. Backpressure: none, requesters must take rvalid.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data
`ifdef ARB_ALIGN_CHECK_EN
  ,
  output logic        f_err,
  output logic        d_err
`endif
);

  logic        w_f_eff;
  logic        w_f_gnt;
  logic        w_d_gnt;
  logic        w_f_mis;
  logic        w_d_mis;
  logic        w_f_acc;
  logic        w_d_acc;

  logic        r_f_rvalid;
  logic [31:0] r_f_rdata;
  logic        r_d_rvalid;
  logic [31:0] r_d_rdata;

  // A flushed fetch never competes for the ROM.
  assign w_f_eff = f_req & ~f_flush;

  inst_arb_prio #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_f_eff (w_f_eff),
    .i_d_req (d_req),
    .o_gnt_f (w_f_gnt),
    .o_gnt_d (w_d_gnt)
  );

`ifdef ARB_ALIGN_CHECK_EN
  assign w_f_mis = (f_addr[1:0] != 2'b00);
  assign w_d_mis = (d_addr[1:0] != 2'b00);
`else
  assign w_f_mis = 1'b0;
  assign w_d_mis = 1'b0;
`endif

  // Misaligned grants are answered locally and leave the ROM idle.
  assign w_f_acc = w_f_gnt & ~w_f_mis;
  assign w_d_acc = w_d_gnt & ~w_d_mis;

  // Drive the ROM from the winner; park on Zero when no access is made.
  always_comb begin
    mem_ce   = RomDisable;
    mem_addr = Zero;
    if (w_f_acc) begin
      mem_ce   = RomEnable;
      mem_addr = f_addr;
    end else if (w_d_acc) begin
      mem_ce   = RomEnable;
      mem_addr = d_addr;
    end
  end

  // Capture ROM data for the granted port; rdata holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_rvalid <= 1'b0;
      r_f_rdata  <= Zero;
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= Zero;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_d_rvalid <= w_d_gnt;
      if (w_f_gnt) begin
        r_f_rdata <= w_f_mis ? Zero : mem_data;
      end
      if (w_d_gnt) begin
        r_d_rdata <= w_d_mis ? Zero : mem_data;
      end
    end
  end

`ifdef ARB_ALIGN_CHECK_EN
  logic r_f_err;
  logic r_d_err;

  // One-cycle error pulse accompanies the Zero response of a misaligned grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_err <= 1'b0;
      r_d_err <= 1'b0;
    end else begin
      r_f_err <= w_f_gnt & w_f_mis;
      r_d_err <= w_d_gnt & w_d_mis;
    end
  end

  assign f_err = r_f_err;
  assign d_err = r_d_err;
`endif

  assign f_gnt    = w_f_gnt;
  assign d_gnt    = w_d_gnt;
  assign f_rvalid = r_f_rvalid;
  assign f_rdata  = r_f_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;

endmodule
